// File: rtl/if_pkg.sv
// Shared constants and the fetch packet type for the instruction-fetch stage.
package if_pkg;

  localparam int PC_WIDTH   = 16;
  localparam int INST_WIDTH = 16;

  localparam logic [INST_WIDTH-1:0] NOP_INST         = 16'h0000;
  localparam logic [PC_WIDTH-1:0]   DEFAULT_RESET_PC = 16'h0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read port: the fetch stage is the master, the memory the slave.
interface if_fetch_stage_if;
  import if_pkg::*;

  logic                  imem_en;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (output imem_en, output imem_addr, input imem_rdata);
  modport slave  (input imem_en, input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that catches the memory response arriving while decode stalls.
module fetch_skid_buf
  import if_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  drain,
  input  logic                  clear,
  input  fetch_pkt_t            load_pkt,
  output logic                  valid,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INST_WIDTH-1:0] inst
);

  fetch_pkt_t pkt;

  // Clear beats load beats drain; the payload is only replaced on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pkt   <= '{pc: '0, inst: NOP_INST};
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pkt   <= load_pkt;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  assign pc   = pkt.pc;
  assign inst = pkt.inst;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle synchronous memory and
// fills the IF/ID register, absorbing decode stalls in a one-entry skid buffer.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  if_fetch_stage_if.master      imem,
  output logic [PC_WIDTH-1:0]   PCOUT,
  output logic [INST_WIDTH-1:0] INST,
  output logic                  inst_valid
);

  logic [PC_WIDTH-1:0] fetch_pc;
  logic                fetch_en;
  logic                inflight;
  logic [PC_WIDTH-1:0] inflight_pc;
  fetch_pkt_t          resp_pkt;
  fetch_pkt_t          ifid;
  logic                skid_valid;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [INST_WIDTH-1:0] skid_inst;
  logic                skid_load;
  logic                skid_drain;

  // No new fetch while decode stalls: the single in-flight response always fits the skid.
  assign fetch_en       = rst & ~stall & ~redirect_valid;
  assign imem.imem_en   = fetch_en;
  assign imem.imem_addr = fetch_pc;

  assign resp_pkt   = '{pc: inflight_pc, inst: imem.imem_rdata};
  assign skid_load  = ~redirect_valid & stall & inflight;
  assign skid_drain = ~redirect_valid & ~stall & skid_valid;

  // Program counter: redirect target wins, otherwise advance (wrapping) on each issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (fetch_en) begin
      fetch_pc <= fetch_pc + PC_WIDTH'(1);
    end
  end

  // Remember which address the memory is answering next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= fetch_en;
      inflight_pc <= fetch_pc;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .drain    (skid_drain),
    .clear    (redirect_valid),
    .load_pkt (resp_pkt),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .inst     (skid_inst)
  );

  // IF/ID register: redirect flush, stall hold, skid first, then live response, else bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid       <= '{pc: '0, inst: NOP_INST};
      inst_valid <= 1'b0;
    end else if (redirect_valid) begin
      inst_valid <= 1'b0;
    end else if (stall) begin
      inst_valid <= inst_valid;
    end else if (skid_valid) begin
      ifid       <= '{pc: skid_pc, inst: skid_inst};
      inst_valid <= 1'b1;
    end else if (inflight) begin
      ifid       <= resp_pkt;
      inst_valid <= 1'b1;
    end else begin
      inst_valid <= 1'b0;
    end
  end

  assign PCOUT = ifid.pc;
  assign INST  = ifid.inst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: queue-based fetch model checked every cycle, plus
// directed scenarios with literal expectations (free-run, stall, redirect,
// redirect under stall, PC wrap on a second instance, async reset).
module tb_if_fetch_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] PCOUT, INST;
  logic        inst_valid;

  logic        stall2 = 1'b0;
  logic        redir2 = 1'b0;
  logic [15:0] redir_pc2 = 16'h0000;
  logic [15:0] w_pc, w_inst;
  logic        w_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if bus ();
  if_fetch_stage_if bus2 ();

  if_fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem(bus.master), .PCOUT(PCOUT), .INST(INST),
    .inst_valid(inst_valid)
  );

  if_fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall2), .redirect_valid(redir2),
    .redirect_pc(redir_pc2), .imem(bus2.master), .PCOUT(w_pc), .INST(w_inst),
    .inst_valid(w_valid)
  );

  // ROM contents: mem[i] = 16'h1000 + i, one-cycle registered read.
  always @(posedge clk) begin
    if (bus.imem_en)  bus.imem_rdata  <= 16'h1000 + bus.imem_addr;
    if (bus2.imem_en) bus2.imem_rdata <= 16'h1000 + bus2.imem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: an ordered list of requested addresses. Anything requested before an
  // edge may be delivered at that edge (oldest first) unless decode stalls; a
  // redirect discards everything outstanding and restarts the stream.
  logic [15:0] m_q[$];
  logic [15:0] m_next = 16'h0000;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_inst = 16'h0000;
  logic        m_valid = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_next  = 16'h0000;
      m_pc    = 16'h0000;
      m_inst  = 16'h0000;
      m_valid = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_valid = 1'b0;
      m_next  = redirect_pc;
    end else if (!stall) begin
      if (m_q.size() > 0) begin
        m_pc    = m_q.pop_front();
        m_inst  = 16'h1000 + m_pc;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      m_q.push_back(m_next);
      m_next = m_next + 16'h0001;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("PCOUT", {16'b0, PCOUT}, {16'b0, m_pc});
    chk("INST", {16'b0, INST}, {16'b0, m_inst});
    chk("imem_en", {31'b0, bus.imem_en}, {31'b0, rst & ~stall & ~redirect_valid});
    chk("imem_addr", {16'b0, bus.imem_addr}, {16'b0, m_next});
    chk("resp_skid_exclusive", {31'b0, dut.inflight & dut.skid_valid}, 32'd0);
  end

  // Capture the first four valid instructions of the wrapping instance.
  logic [31:0] cap [4] = '{32'hDEADDEAD, 32'hDEADDEAD, 32'hDEADDEAD, 32'hDEADDEAD};
  int cap_n = 0;
  always @(negedge clk) begin
    if (w_valid && cap_n < 4) begin
      cap[cap_n] = {w_pc, w_inst};
      cap_n++;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ifid(input string name, input logic [15:0] pc);
    chk({name, "_valid"}, {31'b0, inst_valid}, 32'd1);
    chk({name, "_pc"}, {16'b0, PCOUT}, {16'b0, pc});
    chk({name, "_inst"}, {16'b0, INST}, {16'b0, 16'h1000 + pc});
  endtask

  initial begin
    // Reset state.
    #1;
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_pc", {16'b0, PCOUT}, 32'd0);
    chk("rst_inst", {16'b0, INST}, 32'd0);
    step(); step();
    rst = 1'b1;

    // Free-run: first instruction two edges after release, then one per cycle.
    step();
    chk("first_edge_bubble", {31'b0, inst_valid}, 32'd0);
    for (int i = 0; i <= 5; i++) begin
      step();
      expect_ifid("freerun", 16'(i));
    end

    // Stall for three cycles while PC 5 is held.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_ifid("stall_hold", 16'h0005);
    end
    stall = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      step();
      expect_ifid("after_stall", 16'(i));
    end

    // Redirect to 0x40 while PC 8 is in IF/ID.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    chk("redir_flush", {31'b0, inst_valid}, 32'd0);
    step();
    chk("redir_bubble", {31'b0, inst_valid}, 32'd0);
    step();
    expect_ifid("redir_target", 16'h0040);
    step();
    expect_ifid("redir_next", 16'h0041);
    step();
    expect_ifid("redir_next2", 16'h0042);

    // Redirect while stalled with the skid full.
    stall = 1'b1;
    step();
    expect_ifid("skid_fill_hold", 16'h0042);
    chk("skid_full", {31'b0, dut.skid_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    step();
    redirect_valid = 1'b0;
    chk("rs_flush", {31'b0, inst_valid}, 32'd0);
    chk("rs_skid_clear", {31'b0, dut.skid_valid}, 32'd0);
    chk("rs_no_fetch", {31'b0, bus.imem_en}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rs_stalled_valid", {31'b0, inst_valid}, 32'd0);
      chk("rs_stalled_no_fetch", {31'b0, bus.imem_en}, 32'd0);
    end
    stall = 1'b0;
    #1;
    chk("rs_issue_en", {31'b0, bus.imem_en}, 32'd1);
    chk("rs_issue_addr", {16'b0, bus.imem_addr}, 32'h0010);
    step();
    chk("rs_bubble", {31'b0, inst_valid}, 32'd0);
    step();
    expect_ifid("rs_target", 16'h0010);
    step();
    expect_ifid("rs_next", 16'h0011);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, inst_valid}, 32'd0);
    chk("arst_pc", {16'b0, PCOUT}, 32'd0);
    chk("arst_inst", {16'b0, INST}, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("arst_first_edge_bubble", {31'b0, inst_valid}, 32'd0);
    step();
    expect_ifid("arst_restart", 16'h0000);
    step();
    expect_ifid("arst_restart_next", 16'h0001);

    // Wrapping instance: PC sequence FFFE, FFFF, 0000, 0001.
    chk("wrap_0", cap[0], {16'hFFFE, 16'h0FFE});
    chk("wrap_1", cap[1], {16'hFFFF, 16'h0FFF});
    chk("wrap_2", cap[2], {16'h0000, 16'h1000});
    chk("wrap_3", cap[3], {16'h0001, 16'h1001});

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
